// File: rtl/alu_multiciclo.sv
// Multi-cycle ALU for the EX stage.
// Logic, arithmetic and compare operations complete in one step.
// Shifts are done iteratively, one bit per cycle.
//
// state | meaning
// IDLE  | ready for a request; an accepted request is latched here
// SHIFT | iterative shift in progress, cnt = bit positions still to shift
// DONE  | Result/Zero valid, done pulse high for this single cycle
module alu_multiciclo #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             ready,
  input  logic [3:0]       Op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] Result,
  output logic             Zero,
  output logic             done
);

  localparam int SW = $clog2(WIDTH);

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_AND  = 4'b0010;
  localparam logic [3:0] OP_OR   = 4'b0011;
  localparam logic [3:0] OP_SLL  = 4'b0100;
  localparam logic [3:0] OP_SRL  = 4'b0101;
  localparam logic [3:0] OP_SRA  = 4'b0110;
  localparam logic [3:0] OP_XOR  = 4'b0111;
  localparam logic [3:0] OP_SLT  = 4'b1000;
  localparam logic [3:0] OP_SLTU = 4'b1001;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state;
  logic [3:0]       op_q;
  logic [WIDTH-1:0] acc;
  logic [SW-1:0]    cnt;

  logic [SW-1:0]    shamt;
  logic             is_shift;
  logic [WIDTH-1:0] alu_res;
  logic [WIDTH-1:0] acc_nxt;

  assign shamt    = B[SW-1:0];
  assign is_shift = (Op == OP_SLL) || (Op == OP_SRL) || (Op == OP_SRA);

  // Single-step result; shifts only land here with shamt=0, so they pass A through.
  always_comb begin
    alu_res = A + B;
    case (Op)
      OP_SUB:  alu_res = A - B;
      OP_AND:  alu_res = A & B;
      OP_OR:   alu_res = A | B;
      OP_XOR:  alu_res = A ^ B;
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
      OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (A < B)};
      OP_SLL,
      OP_SRL,
      OP_SRA:  alu_res = A;
      default: alu_res = A + B;
    endcase
  end

  // One-bit shift of the accumulator for the latched shift kind.
  always_comb begin
    acc_nxt = {acc[WIDTH-1], acc[WIDTH-1:1]};
    case (op_q)
      OP_SLL:  acc_nxt = {acc[WIDTH-2:0], 1'b0};
      OP_SRL:  acc_nxt = {1'b0, acc[WIDTH-1:1]};
      default: acc_nxt = {acc[WIDTH-1], acc[WIDTH-1:1]};
    endcase
  end

  // Control FSM with registered ready/done/Result/Zero.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      ready  <= 1'b1;
      done   <= 1'b0;
      Result <= '0;
      Zero   <= 1'b1;
      op_q   <= OP_ADD;
      acc    <= '0;
      cnt    <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            op_q  <= Op;
            ready <= 1'b0;
            if (is_shift && (shamt != '0)) begin
              acc   <= A;
              cnt   <= shamt;
              state <= SHIFT;
            end else begin
              Result <= alu_res;
              Zero   <= (alu_res == '0);
              done   <= 1'b1;
              state  <= DONE;
            end
          end
        end
        SHIFT: begin
          acc <= acc_nxt;
          cnt <= cnt - 1'b1;
          if (cnt == SW'(1)) begin
            Result <= acc_nxt;
            Zero   <= (acc_nxt == '0);
            done   <= 1'b1;
            state  <= DONE;
          end
        end
        DONE: begin
          ready <= 1'b1;
          state <= IDLE;
        end
        default: begin
          ready <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_multiciclo.sv
// Scoreboard bench for alu_multiciclo: driver pushes expected responses,
// monitor pops and compares on every done pulse.
module tb_alu_multiciclo;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        ready;
  logic [3:0]  Op;
  logic [31:0] A;
  logic [31:0] B;
  logic [31:0] Result;
  logic        Zero;
  logic        done;

  alu_multiciclo #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .ready(ready),
    .Op(Op), .A(A), .B(B), .Result(Result), .Zero(Zero), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res;
    int          accept;
    int          lat;
    logic [3:0]  op;
  } exp_t;

  exp_t        sb[$];
  int          cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;
  logic [31:0] hold_res;
  logic        hold_zero;
  bit          in_reset;
  bit          run_done;

  always @(posedge clk) cyc = cyc + 1;

  // Reference: plain arithmetic on the operation definitions.
  function automatic logic [31:0] ref_result(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    int sh;
    sh = int'(b[4:0]);
    case (op)
      4'd1:    return a - b;
      4'd2:    return a & b;
      4'd3:    return a | b;
      4'd4:    return a << sh;
      4'd5:    return a >> sh;
      4'd6:    return $unsigned($signed(a) >>> sh);
      4'd7:    return a ^ b;
      4'd8:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd9:    return (a < b) ? 32'd1 : 32'd0;
      default: return a + b;
    endcase
  endfunction

  function automatic int ref_latency(input logic [3:0] op, input logic [31:0] b);
    if ((op == 4'd4 || op == 4'd5 || op == 4'd6) && b[4:0] != 5'd0)
      return int'(b[4:0]) + 1;
    return 1;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Issue one request: wait for ready (bounded), drive for one edge, push expectation.
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    int   guard;
    guard = 0;
    while (ready !== 1'b1 && guard < 100) begin
      @(posedge clk); #1;
      guard++;
    end
    if (ready !== 1'b1) begin
      n_checks++;
      n_fail++;
      $display("FAIL ready_timeout: ready stayed 0 for %0d cycles", guard);
      return;
    end
    start = 1'b1; Op = op; A = a; B = b;
    e.res    = ref_result(op, a, b);
    e.accept = cyc + 1;
    e.lat    = ref_latency(op, b);
    e.op     = op;
    sb.push_back(e);
    @(posedge clk); #1;
    start = 1'b0;
    Op = 4'($urandom); A = $urandom; B = $urandom;
  endtask

  task automatic wait_drain();
    int guard;
    guard = 0;
    while ((sb.size() != 0 || ready !== 1'b1) && guard < 200) begin
      @(posedge clk); #1;
      guard++;
    end
    if (sb.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain_timeout: %0d responses still pending", sb.size());
    end
  endtask

  // Monitor: compare on done, otherwise outputs must hold.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (run_done) break;
      if (in_reset || rst_n !== 1'b1) continue;
      if (done === 1'b1) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_done: done with empty scoreboard, Result=0x%08h", Result);
        end else begin
          e = sb.pop_front();
          check($sformatf("result_op%0d", e.op), Result, e.res);
          check("zero", {31'd0, Zero}, {31'd0, (e.res == 32'd0)});
          check("latency", cyc + 1 - e.accept, e.lat);
          check("ready_in_done", {31'd0, ready}, 32'd0);
        end
        hold_res  = Result;
        hold_zero = Zero;
      end else begin
        check("result_hold", Result, hold_res);
        check("zero_hold", {31'd0, Zero}, {31'd0, hold_zero});
      end
    end
  end

  initial begin
    int sh;
    logic [3:0] rop;
    rst_n = 1'b0; start = 1'b0; Op = 4'd0; A = '0; B = '0;
    in_reset = 1'b1; run_done = 1'b0;
    hold_res = 32'd0; hold_zero = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_result", Result, 32'd0);
    check("rst_zero", {31'd0, Zero}, 32'd1);
    check("rst_ready", {31'd0, ready}, 32'd1);
    check("rst_done", {31'd0, done}, 32'd0);
    rst_n = 1'b1; in_reset = 1'b0;

    // Directed cases
    issue(4'd0, 32'd5, 32'd7);
    issue(4'd1, 32'd3, 32'd3);
    issue(4'd8, 32'hFFFF_FFFF, 32'd1);
    issue(4'd9, 32'hFFFF_FFFF, 32'd1);
    issue(4'd6, 32'h8000_0000, 32'd4);
    issue(4'd5, 32'h8000_0000, 32'd4);
    issue(4'd4, 32'd1, 32'h20);
    issue(4'd4, 32'd1, 32'd31);
    issue(4'd2, 32'hF0F0_1234, 32'h0FF0_FFFF);
    issue(4'd3, 32'h0000_0000, 32'h0000_0000);
    issue(4'd7, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
    issue(4'd12, 32'hFFFF_FFFF, 32'd1);
    wait_drain();

    // start during a busy SRL must be ignored
    issue(4'd5, 32'hA5A5_0000, 32'd10);
    for (int i = 0; i < 6; i++) begin
      start = 1'b1; Op = 4'd0; A = 32'd100; B = 32'd200;
      check("busy_ready", {31'd0, ready}, 32'd0);
      @(posedge clk); #1;
    end
    start = 1'b0;
    issue(4'd0, 32'd100, 32'd200);
    wait_drain();

    // Synchronous reset mid-shift: in-flight op dropped, no done
    issue(4'd4, 32'h0000_0003, 32'd20);
    repeat (4) @(posedge clk);
    #1;
    in_reset = 1'b1; rst_n = 1'b0;
    sb.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("midrst_result", Result, 32'd0);
    check("midrst_zero", {31'd0, Zero}, 32'd1);
    check("midrst_ready", {31'd0, ready}, 32'd1);
    check("midrst_done", {31'd0, done}, 32'd0);
    hold_res = 32'd0; hold_zero = 1'b1;
    in_reset = 1'b0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      check("midrst_nodone", {31'd0, done}, 32'd0);
    end
    #1;
    issue(4'd1, 32'd10, 32'd4);
    wait_drain();

    // Randomized traffic, biased toward short shifts to bound run time
    for (int i = 0; i < 150; i++) begin
      rop = 4'($urandom_range(0, 15));
      sh = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 31) : $urandom_range(0, 5);
      issue(rop, $urandom, {$urandom_range(0, 1) ? 27'd0 : 27'($urandom), 5'(sh)});
    end
    wait_drain();

    run_done = 1'b1;
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
